// File: rtl/eth_hdr_parse.sv
// eth_hdr_parse: splits an 8-bit receive byte stream, with the FCS already
// removed, into a header side-channel (destination MAC, source MAC,
// EtherType) and an AXI-Stream payload output.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   s_axis_t{data,valid,ready,last,user}  frame byte input (tready registered)
//   m_eth_hdr_{valid,ready}           header handshake, valid held until ready
//   m_eth_dest_mac/src_mac/type       header fields, stable while valid
//   m_eth_payload_axis_t*             payload bytes, tuser passed through
//   busy                              frame in progress
//   error_header_early_termination    1-cycle pulse when a frame ends inside
//                                     the 14-byte header
//
// state   | meaning
// --------+-------------------------------------------------------------
// HEADER  | collecting header bytes 0..13 at index ptr
// PAYLOAD | forwarding payload bytes through the skid buffer until tlast
module eth_hdr_parse (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tuser,
   output logic        m_eth_hdr_valid,
   input  logic        m_eth_hdr_ready,
   output logic [47:0] m_eth_dest_mac,
   output logic [47:0] m_eth_src_mac,
   output logic [15:0] m_eth_type,
   output logic [7:0]  m_eth_payload_axis_tdata,
   output logic        m_eth_payload_axis_tvalid,
   input  logic        m_eth_payload_axis_tready,
   output logic        m_eth_payload_axis_tlast,
   output logic        m_eth_payload_axis_tuser,
   output logic        busy,
   output logic        error_header_early_termination
);

   typedef enum logic [0:0] {HEADER, PAYLOAD} state_t;

   state_t      state, state_next;
   logic [3:0]  ptr, ptr_next;

   // Byte 13 is taken straight from the bus on completion, so only
   // bytes 0..12 need storage.
   logic [7:0]  hdr_shadow [13];

   logic        s_accept;
   logic        hdr_done;
   logic        runt;
   logic        hdr_valid_next;
   logic        tready_next;

   // payload skid buffer
   logic        pl_valid_int;
   logic        tready_int_reg;
   logic        tready_int_early;
   logic [7:0]  temp_tdata;
   logic        temp_tvalid;
   logic        temp_tlast;
   logic        temp_tuser;

   always_comb begin
      s_accept       = s_axis_tvalid && s_axis_tready;
      hdr_done       = (state == HEADER) && s_accept && !s_axis_tlast && (ptr == 4'd13);
      runt           = (state == HEADER) && s_accept && s_axis_tlast;
      pl_valid_int   = (state == PAYLOAD) && s_accept;
      // A header cannot complete while one is pending: tready is low then.
      hdr_valid_next = hdr_done || (m_eth_hdr_valid && !m_eth_hdr_ready);

      state_next = state;
      ptr_next   = ptr;
      case (state)
         HEADER: begin
            if (s_accept) begin
               if (s_axis_tlast || (ptr == 4'd13)) begin
                  ptr_next = 4'd0;
               end else begin
                  ptr_next = ptr + 4'd1;
               end
               if (hdr_done) begin
                  state_next = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (s_accept && s_axis_tlast) begin
               state_next = HEADER;
            end
         end
      endcase

      // Ready for the next cycle is granted only if the skid buffer can
      // still absorb a byte even when the downstream stalls now.
      tready_int_early = m_eth_payload_axis_tready ||
                         (!temp_tvalid && (!m_eth_payload_axis_tvalid || !pl_valid_int));

      tready_next = (state_next == PAYLOAD) ? tready_int_early : !hdr_valid_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                          <= HEADER;
         ptr                            <= 4'd0;
         s_axis_tready                  <= 1'b0;
         m_eth_hdr_valid                <= 1'b0;
         m_eth_dest_mac                 <= 48'd0;
         m_eth_src_mac                  <= 48'd0;
         m_eth_type                     <= 16'd0;
         busy                           <= 1'b0;
         error_header_early_termination <= 1'b0;
         for (int i = 0; i < 13; i++) begin
            hdr_shadow[i] <= 8'd0;
         end
      end else begin
         state                          <= state_next;
         ptr                            <= ptr_next;
         s_axis_tready                  <= tready_next;
         m_eth_hdr_valid                <= hdr_valid_next;
         busy                           <= (state_next == PAYLOAD) || (ptr_next != 4'd0);
         error_header_early_termination <= runt;

         if ((state == HEADER) && s_accept && (ptr != 4'd13)) begin
            hdr_shadow[ptr] <= s_axis_tdata;
         end

         if (hdr_done) begin
            m_eth_dest_mac <= {hdr_shadow[0], hdr_shadow[1], hdr_shadow[2],
                               hdr_shadow[3], hdr_shadow[4], hdr_shadow[5]};
            m_eth_src_mac  <= {hdr_shadow[6], hdr_shadow[7], hdr_shadow[8],
                               hdr_shadow[9], hdr_shadow[10], hdr_shadow[11]};
            m_eth_type     <= {hdr_shadow[12], s_axis_tdata};
         end
      end
   end

   // Output register plus temp register. Input bytes go to the output
   // register when it is free or draining, otherwise into temp.
   always_ff @(posedge clk) begin
      if (rst) begin
         tready_int_reg            <= 1'b0;
         m_eth_payload_axis_tvalid <= 1'b0;
         m_eth_payload_axis_tdata  <= 8'd0;
         m_eth_payload_axis_tlast  <= 1'b0;
         m_eth_payload_axis_tuser  <= 1'b0;
         temp_tvalid               <= 1'b0;
         temp_tdata                <= 8'd0;
         temp_tlast                <= 1'b0;
         temp_tuser                <= 1'b0;
      end else begin
         tready_int_reg <= tready_int_early;
         if (tready_int_reg) begin
            if (m_eth_payload_axis_tready || !m_eth_payload_axis_tvalid) begin
               m_eth_payload_axis_tvalid <= pl_valid_int;
               m_eth_payload_axis_tdata  <= s_axis_tdata;
               m_eth_payload_axis_tlast  <= s_axis_tlast;
               m_eth_payload_axis_tuser  <= s_axis_tuser;
            end else begin
               temp_tvalid <= pl_valid_int;
               temp_tdata  <= s_axis_tdata;
               temp_tlast  <= s_axis_tlast;
               temp_tuser  <= s_axis_tuser;
            end
         end else if (m_eth_payload_axis_tready) begin
            m_eth_payload_axis_tvalid <= temp_tvalid;
            m_eth_payload_axis_tdata  <= temp_tdata;
            m_eth_payload_axis_tlast  <= temp_tlast;
            m_eth_payload_axis_tuser  <= temp_tuser;
            temp_tvalid               <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_eth_hdr_parse.sv
module tb_eth_hdr_parse;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [7:0]  s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic        s_tlast;
   logic        s_tuser;
   logic        hdr_valid;
   logic        hdr_ready = 1'b1;
   logic [47:0] dest_mac;
   logic [47:0] src_mac;
   logic [15:0] eth_type;
   logic [7:0]  pl_tdata;
   logic        pl_tvalid;
   logic        pl_tready;
   logic        pl_tlast;
   logic        pl_tuser;
   logic        busy;
   logic        err;

   eth_hdr_parse dut (
      .clk                            (clk),
      .rst                            (rst),
      .s_axis_tdata                   (s_tdata),
      .s_axis_tvalid                  (s_tvalid),
      .s_axis_tready                  (s_tready),
      .s_axis_tlast                   (s_tlast),
      .s_axis_tuser                   (s_tuser),
      .m_eth_hdr_valid                (hdr_valid),
      .m_eth_hdr_ready                (hdr_ready),
      .m_eth_dest_mac                 (dest_mac),
      .m_eth_src_mac                  (src_mac),
      .m_eth_type                     (eth_type),
      .m_eth_payload_axis_tdata       (pl_tdata),
      .m_eth_payload_axis_tvalid      (pl_tvalid),
      .m_eth_payload_axis_tready      (pl_tready),
      .m_eth_payload_axis_tlast       (pl_tlast),
      .m_eth_payload_axis_tuser       (pl_tuser),
      .busy                           (busy),
      .error_header_early_termination (err)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       last;
      logic       user;
   } beat_t;

   typedef struct packed {
      logic [47:0] dest;
      logic [47:0] src;
      logic [15:0] etype;
   } hdr_t;

   typedef struct {
      int          len;
      logic [47:0] dest;
      logic [47:0] src;
      logic [15:0] etype;
      logic [7:0]  pl_base;
      logic        user_last;
      logic        rand_ready;
      int          exp_hdr;
      int          exp_pl;
      int          exp_err;
   } vec_t;

   int errors = 0;
   int checks = 0;

   // main-owned
   beat_t tx_q[$];
   logic  pl_rand = 1'b0;

   // driver-owned
   int    tx_idx;

   // monitor-owned
   logic  s_hs = 1'b0;
   int    cyc = 0;
   int    err_cnt = 0;
   beat_t rx_q[$];
   hdr_t  hdr_q[$];
   int    hdr_cyc_q[$];
   int    acc_cyc[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // input driver: advances past a byte the DUT took at the last edge
   initial begin
      s_tvalid  = 1'b0;
      s_tdata   = 8'd0;
      s_tlast   = 1'b0;
      s_tuser   = 1'b0;
      pl_tready = 1'b1;
      tx_idx    = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            tx_idx = tx_q.size();
         end else if (s_hs && (tx_idx < tx_q.size())) begin
            tx_idx++;
         end
         if (tx_idx < tx_q.size()) begin
            s_tvalid = 1'b1;
            s_tdata  = tx_q[tx_idx].d;
            s_tlast  = tx_q[tx_idx].last;
            s_tuser  = tx_q[tx_idx].user;
         end else begin
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            s_tuser  = 1'b0;
         end
         pl_tready = pl_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   // monitor: records handshakes that will complete at the next edge
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         s_hs = s_tvalid && s_tready;
         if (s_hs) acc_cyc.push_back(cyc);
         if (pl_tvalid && pl_tready) rx_q.push_back({pl_tdata, pl_tlast, pl_tuser});
         if (hdr_valid && hdr_ready) begin
            hdr_q.push_back({dest_mac, src_mac, eth_type});
            hdr_cyc_q.push_back(cyc);
         end
         if (err) err_cnt++;
      end
   end

   task automatic push_frame(input vec_t v);
      for (int i = 0; i < v.len; i++) begin
         beat_t b;
         if (i < 6)       b.d = v.dest[47-8*i -: 8];
         else if (i < 12) b.d = v.src[47-8*(i-6) -: 8];
         else if (i < 14) b.d = v.etype[15-8*(i-12) -: 8];
         else             b.d = v.pl_base + 8'(i - 14);
         b.last = (i == v.len - 1);
         b.user = b.last ? v.user_last : 1'b0;
         tx_q.push_back(b);
      end
   endtask

   task automatic wait_drain(input int budget, input string tag);
      int n = 0;
      while ((tx_q.size() > tx_idx) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_drain_timeout"}, 64'(n >= budget), 64'd0);
      repeat (20) @(negedge clk);
   endtask

   task automatic check_frame(input vec_t v, input int rb, input int hb, input int eb,
                              input string tag);
      int npl, nh, bad_d, bad_l, bad_u;
      npl = rx_q.size() - rb;
      nh  = hdr_q.size() - hb;
      chk({tag, "_err_cnt"}, 64'(err_cnt - eb), 64'(v.exp_err));
      chk({tag, "_hdr_cnt"}, 64'(nh), 64'(v.exp_hdr));
      chk({tag, "_pl_cnt"}, 64'(npl), 64'(v.exp_pl));
      if ((v.exp_hdr == 1) && (nh >= 1)) begin
         chk({tag, "_dest"}, 64'(hdr_q[hb].dest), 64'(v.dest));
         chk({tag, "_src"}, 64'(hdr_q[hb].src), 64'(v.src));
         chk({tag, "_type"}, 64'(hdr_q[hb].etype), 64'(v.etype));
      end
      if ((npl == v.exp_pl) && (npl > 0)) begin
         bad_d = 0;
         bad_l = 0;
         bad_u = 0;
         for (int k = 0; k < npl; k++) begin
            logic [7:0] exp_d;
            logic       exp_last;
            exp_d    = v.pl_base + 8'(k);
            exp_last = (k == npl - 1);
            if (rx_q[rb+k].d !== exp_d) bad_d++;
            if (rx_q[rb+k].last !== exp_last) bad_l++;
            if (rx_q[rb+k].user !== (exp_last ? v.user_last : 1'b0)) bad_u++;
         end
         chk({tag, "_pl_data_bad"}, 64'(bad_d), 64'd0);
         chk({tag, "_pl_tlast_bad"}, 64'(bad_l), 64'd0);
         chk({tag, "_pl_tuser_bad"}, 64'(bad_u), 64'd0);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int rb, hb, eb;
      rb = rx_q.size();
      hb = hdr_q.size();
      eb = err_cnt;
      pl_rand = v.rand_ready;
      push_frame(v);
      wait_drain(v.len * 4 + 200, tag);
      check_frame(v, rb, hb, eb, tag);
      chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
   endtask

   vec_t vecs[7];

   initial begin
      int rb, hb, hcb, ab, n;

      //          len   dest              src               type      base   ul    rnd   hdr pl    err
      vecs[0] = '{60,   48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800, 8'h00, 1'b0, 1'b0, 1, 46,   0};
      vecs[1] = '{10,   48'h0A0B0C0D0E0F, 48'h102030405060, 16'h0806, 8'h00, 1'b0, 1'b0, 0, 0,    1};
      vecs[2] = '{14,   48'h0A0B0C0D0E0F, 48'h102030405060, 16'h0806, 8'h00, 1'b0, 1'b0, 0, 0,    1};
      vecs[3] = '{60,   48'h001122334455, 48'h66778899AABB, 16'h86DD, 8'h40, 1'b0, 1'b0, 1, 46,   0};
      vecs[4] = '{64,   48'hDEADBEEF0001, 48'h02AABBCCDDEE, 16'h0800, 8'h10, 1'b1, 1'b0, 1, 50,   0};
      vecs[5] = '{15,   48'h111111111111, 48'h222222222222, 16'h88B5, 8'h7E, 1'b0, 1'b0, 1, 1,    0};
      vecs[6] = '{1500, 48'h0000DEADBEEF, 48'h020000000002, 16'h0800, 8'h00, 1'b0, 1'b1, 1, 1486, 0};

      // reset state
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_tready", 64'(s_tready), 64'd0);
      chk("rst_hdr_valid", 64'(hdr_valid), 64'd0);
      chk("rst_pl_valid", 64'(pl_tvalid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_fields", 64'({dest_mac, src_mac, eth_type} != '0), 64'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_release_tready_low", 64'(s_tready), 64'd0);
      @(negedge clk);
      chk("rst_release_tready_high", 64'(s_tready), 64'd1);

      // table-driven frames
      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // header backpressure: two frames back-to-back, header consumer stalled
      rb  = rx_q.size();
      hb  = hdr_q.size();
      hcb = hdr_cyc_q.size();
      ab  = acc_cyc.size();
      @(posedge clk);
      #2;
      hdr_ready = 1'b0;
      pl_rand   = 1'b0;
      push_frame(vecs[0]);
      push_frame(vecs[3]);
      repeat (100) @(negedge clk);
      chk("bp_tready_stalled", 64'(s_tready), 64'd0);
      chk("bp_hdr_pending", 64'(hdr_valid), 64'd1);
      chk("bp_bytes_accepted", 64'(acc_cyc.size() - ab), 64'd60);
      chk("bp_hdr_consumed_early", 64'(hdr_q.size() - hb), 64'd0);
      @(posedge clk);
      #2 hdr_ready = 1'b1;
      wait_drain(600, "bp");
      chk("bp_hdr_cnt", 64'(hdr_q.size() - hb), 64'd2);
      chk("bp_pl_cnt", 64'(rx_q.size() - rb), 64'd92);
      if (hdr_q.size() - hb == 2) begin
         chk("bp_hdr2_dest", 64'(hdr_q[hb+1].dest), 64'(vecs[3].dest));
         chk("bp_hdr2_src", 64'(hdr_q[hb+1].src), 64'(vecs[3].src));
         chk("bp_hdr2_type", 64'(hdr_q[hb+1].etype), 64'(vecs[3].etype));
      end
      if ((acc_cyc.size() > ab + 60) && (hdr_cyc_q.size() > hcb)) begin
         chk("bp_frame2_byte0_cycle", 64'(acc_cyc[ab+60]), 64'(hdr_cyc_q[hcb] + 1));
      end

      // reset during payload byte 20 (input byte 34)
      ab = acc_cyc.size();
      push_frame(vecs[3]);
      n = 0;
      while ((acc_cyc.size() - ab < 34) && (n < 500)) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("mr_reach_byte20_timeout", 64'(n >= 500), 64'd0);
      rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("mr_tready", 64'(s_tready), 64'd0);
      chk("mr_hdr_valid", 64'(hdr_valid), 64'd0);
      chk("mr_pl_valid", 64'(pl_tvalid), 64'd0);
      chk("mr_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      run_vec(vecs[0], "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
